fir_stream_feeder: RTL and testbench

Upstream feeder for the 64-tap serial FIR filter. It accepts samples over a valid/ready stream and buffers them in a small FIFO. It drives the FIR's `ready` enable so that each sample gets exactly TAPS enabled cycles, and it stalls the FIR when no sample is queued. It captures the FIR result after each frame boundary and emits it as a one-cycle-valid output sample.

---
 rtl/fir_pkg.sv | 15 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fir_stream_feeder.sv | 93 +++++++++
 tb/tb_fir_stream_feeder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR stream feeder and its sub-blocks.
package fir_pkg;

  localparam int WIDTH   = 18;
  localparam int TAPS    = 64;
  localparam int PHASE_W = $clog2(TAPS);

  // ST_WAIT: parked at phase TAPS-1 waiting for a queued sample.
  // ST_RUN : walking phases 0..TAPS-2 with the FIR enabled.
  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : fir_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter and no bypass path.
// The head word is visible one cycle after it is pushed.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The storage is never reset, so the head is forced to zero while the
  // FIFO holds nothing; this keeps stale words off the FIR input.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage write on an accepted push.
  // NOTE: the data array has no reset; only pointers and level are reset,
  // which lets the array map onto plain RAM/register cells without reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule : sync_fifo

// File: rtl/fir_stream_feeder.sv
// Upstream feeder for the serial FIR: queues samples, grants the FIR exactly
// TAPS enabled cycles per sample, stalls it when starved, and turns the FIR
// result at each frame boundary into a one-cycle output strobe.
module fir_stream_feeder
  import fir_pkg::*;
#(
  parameter int WIDTH = fir_pkg::WIDTH,
  parameter int TAPS  = fir_pkg::TAPS,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [WIDTH-1:0]       fir_sig,
  output logic                   fir_ready,
  input  logic [WIDTH-1:0]       fir_result,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_valid,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int              PH_W    = $clog2(TAPS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TAPS - 1);
  localparam logic [PH_W-1:0] PH_END  = PH_W'(TAPS - 2);

  state_t          state;
  logic [PH_W-1:0] phase;
  logic            first;
  logic            cap_pend;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            boundary;

  assign s_ready  = !fifo_full;
  assign push     = s_valid && !fifo_full;

  // A boundary is the WAIT cycle in which a sample is available: the FIR
  // latches fir_sig and the FIFO pops on the same edge.
  assign boundary  = (state == ST_WAIT) && !fifo_empty;
  assign fir_ready = (state == ST_RUN) || boundary;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (s_data),
    .pop     (boundary),
    .rd_data (fir_sig),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Frame sequencer: phase mirrors the FIR read index and only moves while
  // the FIR is enabled, so it parks at TAPS-1 whenever the queue is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_WAIT;
      phase <= PH_LAST;
    end else begin
      if (fir_ready) phase <= phase + PH_W'(1);
      case (state)
        ST_WAIT: if (!fifo_empty)     state <= ST_RUN;
        ST_RUN:  if (phase == PH_END) state <= ST_WAIT;
        default:                      state <= ST_WAIT;
      endcase
    end
  end

  // Result capture: the FIR refreshes its output on the boundary edge, so
  // the result is sampled one cycle later. The first boundary after reset
  // closes no real frame and is suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first    <= 1'b1;
      cap_pend <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      cap_pend <= boundary && !first;
      if (boundary) first <= 1'b0;
      m_valid  <= cap_pend;
      if (cap_pend) m_data <= fir_result;
    end
  end

endmodule : fir_stream_feeder

// File: tb/tb_fir_stream_feeder.sv
// Directed bench for fir_stream_feeder. A tiny FIR stand-in counts enabled
// cycles and, at every frame boundary, publishes f(previous sample) with
// f(x) = 3x + 5, so captured results are predictable by hand.
module tb_fir_stream_feeder;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] fir_sig;
  logic         fir_ready;
  logic [W-1:0] fir_result = '0;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic [3:0]   fifo_level;

  int n_cmp  = 0;
  int n_fail = 0;

  // FIR stand-in state
  logic [5:0]   stub_idx     = 6'd63;
  logic [W-1:0] stub_latched = '0;

  fir_stream_feeder #(
    .WIDTH (18),
    .TAPS  (64),
    .DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .fir_sig    (fir_sig),
    .fir_ready  (fir_ready),
    .fir_result (fir_result),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] stub_f(input logic [W-1:0] x);
    return W'(x * 3 + 5);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: FIR stand-in advances on enabled cycles; sample point is #1 after the edge.
  task automatic tick();
    logic         rdy_pre;
    logic [W-1:0] sig_pre;
    rdy_pre = fir_ready;
    sig_pre = fir_sig;
    @(posedge clk);
    #1;
    if (rdy_pre) begin
      if (stub_idx == 6'd63) begin
        fir_result   = stub_f(stub_latched);
        stub_latched = sig_pre;
      end
      stub_idx = stub_idx + 6'd1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    stub_idx     = 6'd63;
    stub_latched = '0;
    fir_result   = '0;
  endtask

  initial begin
    int mv_cnt;
    int hi_cnt;
    int max_lvl;
    logic [W-1:0] sig0;
    sig0 = '0;

    // ---- reset values while rst is held ----
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready",   s_ready,    1);
    check("rst_fir_ready", fir_ready,  0);
    check("rst_fir_sig",   fir_sig,    0);
    check("rst_m_data",    m_data,     0);
    check("rst_m_valid",   m_valid,    0);
    check("rst_level",     fifo_level, 0);
    rst = 1'b0;

    // ---- single sample: 64 enabled cycles, no output strobe ----
    mv_cnt = 0;
    hi_cnt = 0;
    for (int c = 1; c <= 80; c++) begin
      s_valid = (c == 1);
      s_data  = 18'h00100;
      tick();
      if (fir_ready) hi_cnt++;
      if (m_valid)   mv_cnt++;
      case (c)
        1: begin
          check("t1_level_push", fifo_level, 1);
          check("t1_ready_on",   fir_ready,  1);
          check("t1_fir_sig",    fir_sig,    18'h00100);
        end
        2:  check("t1_level_pop",   fifo_level, 0);
        64: check("t1_last_enable", fir_ready,  1);
        65: check("t1_ready_off",   fir_ready,  0);
        default: ;
      endcase
    end
    check("t1_frame_len", hi_cnt, 64);
    check("t1_no_mvalid", mv_cnt, 0);

    // ---- three back-to-back samples after a fresh reset ----
    do_reset();
    mv_cnt = 0;
    for (int c = 1; c <= 200; c++) begin
      s_valid = (c <= 3);
      s_data  = W'(c);
      tick();
      if (m_valid) mv_cnt++;
      case (c)
        2:   check("t2_head_after_b1", fir_sig, 2);
        65:  begin
          check("t2_level_pre_b2", fifo_level, 2);
          check("t2_mv_b2_early",  m_valid,    0);
        end
        66:  begin
          check("t2_level_b2",     fifo_level, 1);
          check("t2_head_after_b2", fir_sig,   3);
          check("t2_mv_b2_early2", m_valid,    0);
        end
        67:  begin
          check("t2_mv_b2",   m_valid, 1);
          check("t2_data_b2", m_data,  18'h00008);
        end
        68:  check("t2_mv_b2_end", m_valid, 0);
        130: check("t2_level_b3", fifo_level, 0);
        131: begin
          check("t2_mv_b3",   m_valid, 1);
          check("t2_data_b3", m_data,  18'h0000B);
        end
        192: check("t2_last_enable", fir_ready, 1);
        193: check("t2_ready_off",   fir_ready, 0);
        default: ;
      endcase
    end
    check("t2_mv_count", mv_cnt, 2);

    // ---- continuous s_valid fills the FIFO, then starve for 100 cycles ----
    max_lvl = 0;
    for (int c = 1; c <= 740; c++) begin
      s_valid = (c <= 67);
      s_data  = 18'h00AAA;
      tick();
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      case (c)
        8:   begin
          check("t3_level_7",   fifo_level, 7);
          check("t3_ready_7",   s_ready,    1);
        end
        9:   begin
          check("t3_level_full", fifo_level, 8);
          check("t3_ready_full", s_ready,    0);
        end
        65:  check("t3_ready_held", s_ready, 0);
        66:  begin
          check("t3_level_pop", fifo_level, 7);
          check("t3_ready_pop", s_ready,    1);
        end
        67:  begin
          check("t3_level_refill", fifo_level, 8);
          check("t3_ready_refill", s_ready,    0);
        end
        640: check("t4_last_enable", fir_ready, 1);
        641: begin
          check("t4_drained", fifo_level, 0);
          sig0 = fir_sig;
        end
        default: ;
      endcase
      if (c >= 641) begin
        check("t4_starve_ready", fir_ready, 0);
        check("t4_starve_sig",   fir_sig,   sig0);
      end
    end
    check("t3_max_level", (max_lvl <= 8), 1);

    // ---- resume: push into empty FIFO, no bypass ----
    s_valid = 1'b1;
    s_data  = 18'h01234;
    #1;
    check("t4_no_bypass", fir_ready, 0);
    tick();
    s_valid = 1'b0;
    check("t4_resume_ready", fir_ready,  1);
    check("t4_resume_sig",   fir_sig,    18'h01234);
    check("t4_resume_level", fifo_level, 1);

    // ---- queue four, then push and pop on the same boundary at level 4 ----
    for (int r = 1; r <= 85; r++) begin
      s_valid = ((r >= 2) && (r <= 5)) || (r == 65);
      s_data  = W'(r * 17);
      tick();
      case (r)
        1:  begin
          check("t5_level_b",  fifo_level, 0);
          check("t5_mv_early", m_valid,    0);
        end
        2:  begin
          check("t4_mv",   m_valid, 1);
          check("t4_data", m_data,  18'h02003);
        end
        5:  check("t5_level_4", fifo_level, 4);
        64: begin
          check("t5_level_pre", fifo_level, 4);
          check("t5_head_pre",  fir_sig,    18'h00022);
          check("t5_boundary",  fir_ready,  1);
        end
        65: begin
          check("t5_level_same", fifo_level, 4);
          check("t5_head_new",   fir_sig,    18'h00033);
        end
        66: begin
          check("t5_mv",   m_valid, 1);
          check("t5_data", m_data,  18'h036A1);
        end
        85: begin
          check("t6_pre_level", fifo_level, 4);
          check("t6_pre_data",  m_data,     18'h036A1);
        end
        default: ;
      endcase
    end

    // ---- asynchronous reset in RUN at phase 20 ----
    #2;
    rst = 1'b1;
    #1;
    check("t6_s_ready",   s_ready,    1);
    check("t6_fir_ready", fir_ready,  0);
    check("t6_fir_sig",   fir_sig,    0);
    check("t6_m_data",    m_data,     0);
    check("t6_m_valid",   m_valid,    0);
    check("t6_level",     fifo_level, 0);
    @(posedge clk);
    #1;
    check("t6_ready_held", fir_ready, 0);
    rst          = 1'b0;
    stub_idx     = 6'd63;
    stub_latched = '0;
    fir_result   = '0;
    check("t6_rel_level", fifo_level, 0);
    check("t6_rel_ready", fir_ready,  0);
    s_valid = 1'b1;
    s_data  = 18'h00077;
    tick();
    s_valid = 1'b0;
    check("t6_wait_ready", fir_ready,  1);
    check("t6_wait_sig",   fir_sig,    18'h00077);
    tick();
    check("t6_run_level",  fifo_level, 0);
    check("t6_run_ready",  fir_ready,  1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fir_stream_feeder
